fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer for the CPU core. Owns the program counter, drives the

---
 rtl/cpu_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/fetch_ctrl.sv | 92 +++++++++
 tb/tb_fetch_ctrl.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants.
//   XLEN          - datapath width
//   NOP_INSTR     - canonical NOP (addi x0, x0, 0)
//   fetch_entry_t - {pc, instr} payload carried from fetch to decode
package cpu_pkg;
    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush.
//   clk, rst_n  - clock, async active-low reset
//   flush       - empties the FIFO; wins over push and pop
//   push        - write push_data (caller guarantees not full)
//   push_data   - entry to write
//   pop         - remove head (caller guarantees not empty)
//   head        - entry at head (undefined when empty)
//   empty       - no entries
//   count       - number of entries held
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         empty,
    output logic [CW-1:0] count
);
    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;

    // Pointer increment that also handles non-power-of-two depths.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end

    // Storage; contents are only observable through count, so no reset needed.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;
endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the instruction memory
// address (1-cycle registered read), buffers returned words and presents
// {pc, instr} to decode with valid/ready. Accepts redirects from execute.
//   clk, rst_n     - clock, async active-low reset
//   fetch_en_i     - allow new fetches
//   redirect_i     - redirect request; flushes buffered/in-flight words
//   redirect_pc_i  - redirect target (low two bits ignored)
//   imem_pc_o      - instruction memory address (= pc_q)
//   imem_instr_i   - word for the address presented the previous cycle
//   instr_valid_o  - decode entry valid (masked during redirect)
//   instr_ready_i  - decode accepts entry
//   instr_o        - instruction at buffer head (NOP when empty)
//   instr_pc_o     - PC of instr_o (0 when empty)
//   fetch_idle_o   - nothing in flight and buffer empty
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_pc_o,
    input  logic [31:0] imem_instr_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        fetch_idle_o
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    // One extra bit so count + inflight cannot wrap.
    localparam int unsigned SW = CW + 1;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] inflight_pc_q;
    logic            inflight_q;

    fetch_entry_t    fifo_head;
    fetch_entry_t    push_entry;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic            pop;
    logic            issue;
    logic [SW-1:0]   credit_used;

    assign pop = instr_valid_o & instr_ready_i;

    // Credit check: buffered + in-flight after this cycle's pop must leave room.
    assign credit_used = SW'(fifo_count) + SW'(inflight_q) - SW'(pop);
    assign issue       = fetch_en_i & ~redirect_i & (credit_used < SW'(FIFO_DEPTH));

    assign push_entry = '{pc: inflight_pc_q, instr: imem_instr_i};

    // PC and in-flight tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            if (redirect_i)  pc_q <= {redirect_pc_i[31:2], 2'b00};
            else if (issue)  pc_q <= pc_q + 32'd4;
            inflight_q <= issue;
            if (issue) inflight_pc_q <= pc_q;
        end
    end

    // Returned word pushed unconditionally; a coincident redirect flush drops it.
    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_i),
        .push      (inflight_q),
        .push_data (push_entry),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign imem_pc_o     = pc_q;
    assign instr_valid_o = ~fifo_empty & ~redirect_i;
    assign instr_o       = fifo_empty ? NOP_INSTR : fifo_head.instr;
    assign instr_pc_o    = fifo_empty ? '0 : fifo_head.pc;
    assign fetch_idle_o  = ~inflight_q & fifo_empty;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a randomized
// run checked against an in-order instruction-stream model.
module tb_fetch_ctrl;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ready;

    logic [31:0] imem_pc0, imem_q0, instr0, pc0;
    logic        valid0, idle0;
    logic [31:0] imem_pc1, imem_q1, instr1, pc1;
    logic        valid1, idle1;

    int nrun;
    int nfail;

    fetch_ctrl #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en_i(fetch_en), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .imem_pc_o(imem_pc0), .imem_instr_i(imem_q0),
        .instr_valid_o(valid0), .instr_ready_i(ready), .instr_o(instr0),
        .instr_pc_o(pc0), .fetch_idle_o(idle0)
    );

    fetch_ctrl #(.RESET_PC(WRAP_PC), .FIFO_DEPTH(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .fetch_en_i(fetch_en), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .imem_pc_o(imem_pc1), .imem_instr_i(imem_q1),
        .instr_valid_o(valid1), .instr_ready_i(ready), .instr_o(instr1),
        .instr_pc_o(pc1), .fetch_idle_o(idle1)
    );

    // Memory contents: a bijective scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
    endfunction

    // Instruction memories with 1-cycle registered read, NOP in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_q0 <= NOP;
            imem_q1 <= NOP;
        end else begin
            imem_q0 <= mem_word(imem_pc0);
            imem_q1 <= mem_word(imem_pc1);
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // Reset, then release at a negedge: that negedge starts cycle 0.
    task automatic do_reset(input logic fe, input logic rdy);
        @(negedge clk);
        rst_n = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        fetch_en = 1'b0;
        ready = 1'b0;
        repeat (2) @(negedge clk);
        fetch_en = fe;
        ready = rdy;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        fetch_en = 1'b1;
        ready = 1'b1;
        redirect = 1'b0;
        #1;
        nrun++;
        if (valid0 !== 1'b0 || instr0 !== NOP || pc0 !== 32'h0 || imem_pc0 !== 32'h0 || idle0 !== 1'b1) begin
            nfail++;
            $display("FAIL reset_state: got v=%b i=%h pc=%h ipc=%h idle=%b required v=0 i=%h pc=0 ipc=0 idle=1",
                     valid0, instr0, pc0, imem_pc0, idle0, NOP);
        end
        nrun++;
        if (imem_pc1 !== WRAP_PC || idle1 !== 1'b1 || valid1 !== 1'b0) begin
            nfail++;
            $display("FAIL reset_pc_param: got ipc=%h idle=%b v=%b required ipc=%h idle=1 v=0",
                     imem_pc1, idle1, valid1, WRAP_PC);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        do_reset(1'b1, 1'b1);
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            nrun++;
            if (valid0 !== 1'(c >= 2)) begin
                nfail++;
                $display("FAIL stream_valid c%0d: got %b required %b", c, valid0, c >= 2);
            end else if (c >= 2 && (pc0 !== 32'(4 * (c - 2)) || instr0 !== mem_word(32'(4 * (c - 2))))) begin
                nfail++;
                $display("FAIL stream_entry c%0d: got pc=%h i=%h required pc=%h i=%h",
                         c, pc0, instr0, 32'(4 * (c - 2)), mem_word(32'(4 * (c - 2))));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp;
        int got;
        do_reset(1'b1, 1'b0);
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (c >= 2) begin
                nrun++;
                if (valid0 !== 1'b1 || pc0 !== 32'h0) begin
                    nfail++;
                    $display("FAIL bp_hold c%0d: got v=%b pc=%h required v=1 pc=0", c, valid0, pc0);
                end
            end
        end
        nrun++;
        if (imem_pc0 !== 32'h8) begin
            nfail++;
            $display("FAIL bp_imem_stall: got %h required 00000008", imem_pc0);
        end
        exp = 32'h0;
        got = 0;
        for (int c = 6; c < 16; c++) begin
            @(negedge clk);
            ready = 1'b1;
            #1;
            if (valid0 && ready) begin
                nrun++;
                if (pc0 !== exp || instr0 !== mem_word(exp)) begin
                    nfail++;
                    $display("FAIL bp_release c%0d: got pc=%h i=%h required pc=%h i=%h",
                             c, pc0, instr0, exp, mem_word(exp));
                end
                exp = exp + 32'd4;
                got++;
            end
        end
        nrun++;
        if (got != 10) begin
            nfail++;
            $display("FAIL bp_throughput: got %0d deliveries required 10", got);
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b1, 1'b0);
        repeat (4) @(negedge clk);
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0102;
        ready = 1'b1;
        #1;
        nrun++;
        if (valid0 !== 1'b0) begin
            nfail++;
            $display("FAIL redir_mask_R: got valid=%b required 0", valid0);
        end
        @(negedge clk);
        redirect = 1'b0;
        #1;
        nrun++;
        if (valid0 !== 1'b0 || imem_pc0 !== 32'h100) begin
            nfail++;
            $display("FAIL redir_R1: got v=%b ipc=%h required v=0 ipc=00000100", valid0, imem_pc0);
        end
        @(negedge clk);
        #1;
        nrun++;
        if (valid0 !== 1'b0) begin
            nfail++;
            $display("FAIL redir_R2: got valid=%b required 0", valid0);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            nrun++;
            if (valid0 !== 1'b1 || pc0 !== 32'h100 + 32'(4 * k) || instr0 !== mem_word(32'h100 + 32'(4 * k))) begin
                nfail++;
                $display("FAIL redir_stream R+%0d: got v=%b pc=%h required v=1 pc=%h",
                         k + 3, valid0, pc0, 32'h100 + 32'(4 * k));
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] e;
        do_reset(1'b1, 1'b1);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (c >= 2) begin
                e = WRAP_PC + 32'(4 * (c - 2));
                nrun++;
                if (valid1 !== 1'b1 || pc1 !== e || instr1 !== mem_word(e)) begin
                    nfail++;
                    $display("FAIL wrap c%0d: got v=%b pc=%h i=%h required v=1 pc=%h i=%h",
                             c, valid1, pc1, instr1, e, mem_word(e));
                end
            end
        end
    endtask

    task automatic test_fetch_en();
        logic [31:0] exp;
        int idle_k;
        do_reset(1'b1, 1'b1);
        exp = 32'h0;
        idle_k = -1;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (valid0 && ready) exp = exp + 32'd4;
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) fetch_en = 1'b0;
            #1;
            if (valid0 && ready) begin
                nrun++;
                if (pc0 !== exp) begin
                    nfail++;
                    $display("FAIL fen_drain k%0d: got pc=%h required %h", k, pc0, exp);
                end
                exp = exp + 32'd4;
            end
            nrun++;
            if (imem_pc0 !== 32'h10) begin
                nfail++;
                $display("FAIL fen_imem_hold k%0d: got %h required 00000010", k, imem_pc0);
            end
            if (idle0 && idle_k < 0) idle_k = k;
        end
        nrun++;
        if (idle_k < 0 || idle_k > 2 || exp !== 32'h10) begin
            nfail++;
            $display("FAIL fen_idle: got idle at k=%0d next=%h required k<=2 next=00000010", idle_k, exp);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) fetch_en = 1'b1;
            #1;
            if (valid0 && ready) begin
                nrun++;
                if (pc0 !== exp) begin
                    nfail++;
                    $display("FAIL fen_resume k%0d: got pc=%h required %h", k, pc0, exp);
                end
                exp = exp + 32'd4;
            end
        end
        nrun++;
        if (exp !== 32'h20) begin
            nfail++;
            $display("FAIL fen_resume_count: got next=%h required 00000020", exp);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b1, 1'b0);
        repeat (3) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        nrun++;
        if (valid0 !== 1'b0 || instr0 !== NOP || pc0 !== 32'h0 || imem_pc0 !== 32'h0 || idle0 !== 1'b1) begin
            nfail++;
            $display("FAIL midreset_state: got v=%b i=%h pc=%h ipc=%h idle=%b required v=0 i=%h pc=0 ipc=0 idle=1",
                     valid0, instr0, pc0, imem_pc0, idle0, NOP);
        end
        @(negedge clk);
        ready = 1'b1;
        fetch_en = 1'b1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            nrun++;
            if (valid0 !== 1'(c >= 2) || (c >= 2 && pc0 !== 32'(4 * (c - 2)))) begin
                nfail++;
                $display("FAIL midreset_restart c%0d: got v=%b pc=%h required v=%b pc=%h",
                         c, valid0, pc0, c >= 2, 32'(4 * (c - 2)));
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] exp, prev_pc, prev_imem;
        logic prev_stall, prev_hold, found;
        int ndeliv;
        do_reset(1'b1, 1'b1);
        exp = 32'h0;
        prev_stall = 1'b0;
        prev_hold = 1'b0;
        prev_pc = '0;
        prev_imem = '0;
        ndeliv = 0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            fetch_en = ($urandom_range(0, 99) < 85);
            ready = ($urandom_range(0, 99) < 60);
            redirect = ($urandom_range(0, 99) < 5) || (redirect && $urandom_range(0, 1) == 1);
            if (redirect) redirect_pc = $urandom;
            #1;
            if (prev_hold) begin
                nrun++;
                if (imem_pc0 !== prev_imem) begin
                    nfail++;
                    $display("FAIL rnd_imem_hold n%0d: got %h required %h", n, imem_pc0, prev_imem);
                end
            end
            if (redirect) begin
                nrun++;
                if (valid0 !== 1'b0) begin
                    nfail++;
                    $display("FAIL rnd_redir_mask n%0d: got valid=%b required 0", n, valid0);
                end
                exp = {redirect_pc[31:2], 2'b00};
            end else begin
                if (prev_stall) begin
                    nrun++;
                    if (valid0 !== 1'b1 || pc0 !== prev_pc) begin
                        nfail++;
                        $display("FAIL rnd_stable n%0d: got v=%b pc=%h required v=1 pc=%h", n, valid0, pc0, prev_pc);
                    end
                end
                if (valid0 && ready) begin
                    nrun++;
                    if (pc0 !== exp || instr0 !== mem_word(exp)) begin
                        nfail++;
                        $display("FAIL rnd_order n%0d: got pc=%h i=%h required pc=%h i=%h",
                                 n, pc0, instr0, exp, mem_word(exp));
                    end
                    exp = exp + 32'd4;
                    ndeliv++;
                end
            end
            prev_stall = valid0 & ~ready & ~redirect;
            prev_pc = pc0;
            prev_hold = ~redirect & ~fetch_en;
            prev_imem = imem_pc0;
        end
        nrun++;
        if (ndeliv < 50) begin
            nfail++;
            $display("FAIL rnd_progress: got %0d deliveries required >=50", ndeliv);
        end
        @(negedge clk);
        fetch_en = 1'b1;
        ready = 1'b1;
        redirect = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (valid0) found = 1'b1;
        end
        nrun++;
        if (!found || pc0 !== exp) begin
            nfail++;
            $display("FAIL rnd_final: got found=%b pc=%h required found=1 pc=%h", found, pc0, exp);
        end
        @(negedge clk);
        fetch_en = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            #1;
            if (idle0) found = 1'b1;
        end
        nrun++;
        if (!found) begin
            nfail++;
            $display("FAIL rnd_idle: got idle=%b after 10 cycles required 1", idle0);
        end
    endtask

    initial begin
        nrun = 0;
        nfail = 0;
        rst_n = 1'b0;
        fetch_en = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_fetch_en();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nrun, nfail);
        $finish;
    end
endmodule
